// File: rtl/laser_pkg.sv
// laser_pkg: shared constants, state encoding and coverage test for the LASER host
package laser_pkg;
    localparam int NPTS = 40;
    localparam int CW = 4;
    localparam logic [8:0] R2 = 9'd16;

    typedef enum logic [2:0] {S_IDLE, S_RESET_DUT, S_FEED, S_WAIT, S_SCORE, S_REPORT} state_t;

    // Same coverage rule the LASER core uses: squared distance within R2
    function automatic logic is_covered(input logic [CW-1:0] px, py, cx, cy);
        logic [CW-1:0] dx, dy;
        logic [7:0] sx, sy;
        dx = px > cx ? px - cx : cx - px;
        dy = py > cy ? py - cy : cy - py;
        sx = {4'b0, dx} * {4'b0, dx};
        sy = {4'b0, dy} * {4'b0, dy};
        return ({1'b0, sx} + {1'b0, sy}) <= R2;
    endfunction
endpackage

// File: rtl/laser_point_buf.sv
// laser_point_buf: 40-entry point store with write pointer, full flag and combinational read
module laser_point_buf
    import laser_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic          clr,
    input  logic [CW-1:0] wr_x,
    input  logic [CW-1:0] wr_y,
    input  logic [5:0]    rd_idx,
    output logic [CW-1:0] rd_x,
    output logic [CW-1:0] rd_y,
    output logic [5:0]    cnt_n,
    output logic          full
);
    logic [2*CW-1:0] mem [NPTS];
    logic [5:0] cnt;
    logic we;

    assign full = cnt == 6'(NPTS);
    assign we = wr_en && !full;
    assign cnt_n = clr ? '0 : cnt + 6'(we);
    assign {rd_x, rd_y} = rd_idx < 6'(NPTS) ? mem[rd_idx] : '0;

    // write pointer / load count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt <= '0;
        else     cnt <= cnt_n;
    end

    // point storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (we) mem[cnt] <= {wr_x, wr_y};
    end
endmodule

// File: rtl/laser_host.sv
// laser_host: loads 40 points, drives the LASER core, captures its circles and scores them
module laser_host
    import laser_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PT_VALID,
    input  logic [CW-1:0] PT_X,
    input  logic [CW-1:0] PT_Y,
    output logic          PT_READY,
    input  logic          START,
    output logic          BUSY,
    output logic          L_RST,
    output logic [CW-1:0] L_X,
    output logic [CW-1:0] L_Y,
    input  logic          L_DONE,
    input  logic [CW-1:0] L_C1X,
    input  logic [CW-1:0] L_C1Y,
    input  logic [CW-1:0] L_C2X,
    input  logic [CW-1:0] L_C2Y,
    output logic          RES_VALID,
    output logic [5:0]    SCORE,
    output logic          TOUT,
    output logic [CW-1:0] RES_C1X,
    output logic [CW-1:0] RES_C1Y,
    output logic [CW-1:0] RES_C2X,
    output logic [CW-1:0] RES_C2Y
);
    state_t state, state_n;
    logic [5:0] idx, idx_n, cnt_n, acc;
    logic [23:0] wcnt;
    logic [CW-1:0] rd_x, rd_y, px, py, c1x, c1y, c2x, c2y;
    logic full, hit, tmo;

    laser_point_buf u_buf (
        .CLK    (CLK),
        .RST    (RST),
        .wr_en  (PT_VALID && PT_READY),
        .clr    (state == S_REPORT),
        .wr_x   (PT_X),
        .wr_y   (PT_Y),
        .rd_idx (idx_n),
        .rd_x   (rd_x),
        .rd_y   (rd_y),
        .cnt_n  (cnt_n),
        .full   (full)
    );

    assign hit = is_covered(px, py, c1x, c1y) || is_covered(px, py, c2x, c2y);
    assign tmo = state == S_WAIT;

    // next state and index; the buffer is read at the next index so point registers are ready on entry
    always_comb begin
        state_n = state;
        idx_n = idx;
        case (state)
            S_IDLE:      state_n = START && full ? S_RESET_DUT : S_IDLE;
            S_RESET_DUT: begin state_n = S_FEED; idx_n = '0; end
            S_FEED:      if (idx == 6'(NPTS - 1)) state_n = S_WAIT; else idx_n = idx + 6'd1;
            S_WAIT:      if (L_DONE) begin state_n = S_SCORE; idx_n = '0; end else if (wcnt == TIMEOUT) state_n = S_REPORT;
            S_SCORE:     if (idx == 6'(NPTS - 1)) state_n = S_REPORT; else idx_n = idx + 6'd1;
            S_REPORT:    state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            idx <= '0;
            wcnt <= '0;
            acc <= '0;
            {px, py, c1x, c1y, c2x, c2y} <= '0;
            L_RST <= 1'b1;
            PT_READY <= 1'b1;
            {BUSY, RES_VALID, TOUT, SCORE, L_X, L_Y} <= '0;
            {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            wcnt <= state == S_WAIT ? wcnt + 24'd1 : '0;
            acc <= state == S_SCORE ? acc + 6'(hit) : '0;
            {px, py} <= {rd_x, rd_y};
            if (state == S_WAIT && L_DONE) {c1x, c1y, c2x, c2y} <= {L_C1X, L_C1Y, L_C2X, L_C2Y};
            L_RST <= state_n == S_RESET_DUT;
            BUSY <= state_n != S_IDLE;
            PT_READY <= state_n == S_IDLE && cnt_n < 6'(NPTS);
            RES_VALID <= state_n == S_REPORT;
            {L_X, L_Y} <= state_n == S_FEED ? {rd_x, rd_y} : '0;
            if (state_n == S_REPORT) begin
                TOUT <= tmo;
                SCORE <= tmo ? '0 : acc + 6'(hit);
                {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} <= tmo ? '0 : {c1x, c1y, c2x, c2y};
            end
        end
    end
endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: directed checks of loading, feed timing, scoring, timeout and mid-run reset
module tb_laser_host;
    import laser_pkg::*;

    logic CLK = 1'b0, RST = 1'b1, PT_VALID = 1'b0, START = 1'b0, L_DONE = 1'b0;
    logic [3:0] PT_X = '0, PT_Y = '0, L_C1X = '0, L_C1Y = '0, L_C2X = '0, L_C2Y = '0;
    logic PT_READY, BUSY, L_RST, RES_VALID, TOUT;
    logic [3:0] L_X, L_Y, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
    logic [5:0] SCORE;
    logic [3:0] px [NPTS];
    logic [3:0] py [NPTS];
    int n_checks = 0, n_errors = 0;

    laser_host #(.TIMEOUT(24'd100)) dut (
        .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .PT_X(PT_X), .PT_Y(PT_Y), .PT_READY(PT_READY),
        .START(START), .BUSY(BUSY), .L_RST(L_RST), .L_X(L_X), .L_Y(L_Y), .L_DONE(L_DONE),
        .L_C1X(L_C1X), .L_C1Y(L_C1Y), .L_C2X(L_C2X), .L_C2Y(L_C2Y), .RES_VALID(RES_VALID),
        .SCORE(SCORE), .TOUT(TOUT), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X),
        .RES_C2Y(RES_C2Y)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            PT_VALID = 1'b1;
            PT_X = px[i];
            PT_Y = py[i];
            tick();
        end
        PT_VALID = 1'b0;
    endtask

    task automatic run(input bit do_done, input logic [3:0] c1x, c1y, c2x, c2y,
                       input int exp_score, input int exp_tout);
        int n;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("lrst_high", int'(L_RST), 1);
        check("busy_run", int'(BUSY), 1);
        for (int k = 0; k < NPTS; k++) begin
            tick();
            if (k == 0) check("lrst_low", int'(L_RST), 0);
            check("feed_x", int'(L_X), int'(px[k]));
            check("feed_y", int'(L_Y), int'(py[k]));
        end
        tick();
        check("wait_x", int'(L_X), 0);
        n = 0;
        if (do_done) begin
            {L_C1X, L_C1Y, L_C2X, L_C2Y} = {c1x, c1y, c2x, c2y};
            L_DONE = 1'b1;
            tick();
            L_DONE = 1'b0;
            {L_C1X, L_C1Y, L_C2X, L_C2Y} = '0;
            n = 1;
        end
        while (!RES_VALID && n < 300) begin
            tick();
            n++;
        end
        check("res_latency", n, do_done ? 41 : 101);
        check("score", int'(SCORE), exp_score);
        check("tout", int'(TOUT), exp_tout);
        check("res_c1x", int'(RES_C1X), do_done ? int'(c1x) : 0);
        check("res_c1y", int'(RES_C1Y), do_done ? int'(c1y) : 0);
        check("res_c2x", int'(RES_C2X), do_done ? int'(c2x) : 0);
        check("res_c2y", int'(RES_C2Y), do_done ? int'(c2y) : 0);
        tick();
        check("res_pulse", int'(RES_VALID), 0);
        check("busy_idle", int'(BUSY), 0);
        check("ready_idle", int'(PT_READY), 1);
        check("score_hold", int'(SCORE), exp_score);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_lrst", int'(L_RST), 1);
        check("rst_ready", int'(PT_READY), 1);
        check("rst_busy", int'(BUSY), 0);
        check("rst_valid", int'(RES_VALID), 0);
        check("rst_tout", int'(TOUT), 0);
        check("rst_score", int'(SCORE), 0);
        check("rst_lx", int'(L_X), 0);
        RST = 1'b0;
        tick();
        check("lrst_release", int'(L_RST), 0);

        for (int i = 0; i < NPTS; i++) begin px[i] = 4'd7; py[i] = 4'd7; end
        load(0, NPTS);
        run(1'b1, 4'd7, 4'd7, 4'd0, 4'd0, 40, 0);

        for (int i = 0; i < NPTS; i++) begin px[i] = 4'(i % 16); py[i] = 4'(i / 16); end
        load(0, NPTS);
        run(1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 22, 0);

        for (int i = 0; i < NPTS; i++) begin px[i] = 4'd8; py[i] = 4'd8; end
        px[0] = 4'd4; py[0] = 4'd0;
        px[1] = 4'd3; py[1] = 4'd2;
        px[2] = 4'd0; py[2] = 4'd4;
        px[3] = 4'd3; py[3] = 4'd3;
        px[4] = 4'd4; py[4] = 4'd1;
        load(0, NPTS - 1);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_39a", int'(BUSY), 0);
        tick();
        check("busy_39b", int'(BUSY), 0);
        check("ready_39", int'(PT_READY), 1);
        load(NPTS - 1, NPTS);
        check("ready_full", int'(PT_READY), 0);
        PT_VALID = 1'b1;
        PT_X = 4'd15;
        PT_Y = 4'd15;
        tick();
        PT_VALID = 1'b0;
        check("ready_full2", int'(PT_READY), 0);
        run(1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 3, 0);

        load(0, NPTS);
        run(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1);

        load(0, NPTS);
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (21) tick();
        check("feed20_x", int'(L_X), int'(px[20]));
        RST = 1'b1;
        #1;
        check("abort_lrst", int'(L_RST), 1);
        check("abort_busy", int'(BUSY), 0);
        check("abort_ready", int'(PT_READY), 1);
        check("abort_lx", int'(L_X), 0);
        tick();
        RST = 1'b0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("empty_start", int'(BUSY), 0);
        for (int i = 0; i < NPTS; i++) begin px[i] = 4'(i % 16); py[i] = 4'(i / 16); end
        load(0, NPTS);
        run(1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 22, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
